// File: rtl/ps2_tx_pkg.sv
// ps2_tx_pkg
//   Shared definitions for the PS/2 device-side transmitter.
//   Contents:
//     - one-hot FSM state encoding
//     - frame length and per-bit phase constants (4 clock_quarter cycles per bit)
//     - odd parity helper used when a byte is latched into the frame shifter
package ps2_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_WAIT_BUS = 4'b0010,
    ST_SEND     = 4'b0100,
    ST_ABORT    = 4'b1000
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;

  // Index of the stop bit inside the frame (last bit sent).
  localparam logic [3:0] STOP_BIT_IDX = 4'(PS2_FRAME_BITS - 1);

  // Phases of one PS/2 bit; the device pulls the clock low in the two middle phases.
  localparam logic [1:0] PH_SETUP = 2'd0;
  localparam logic [1:0] PH_LOW0  = 2'd1;
  localparam logic [1:0] PH_LOW1  = 2'd2;
  localparam logic [1:0] PH_HIGH  = 2'd3;

  // Odd parity: data plus parity bit always hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// ps2_sync
//   Single register stage on the two PS/2 lines, shared by the rx and tx sides.
//   Ports:
//     clock_quarter  in   system clock (4 cycles per PS/2 bit)
//     reset          in   synchronous, active-high
//     clk_in         in   raw PS2_CLK line
//     dat_in         in   raw PS2_DAT line
//     clk_sync       out  PS2_CLK delayed by one cycle
//     dat_sync       out  PS2_DAT delayed by one cycle
module ps2_sync (
  input  logic clock_quarter,
  input  logic reset,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_sync,
  output logic dat_sync
);

  logic clk_sync_r;
  logic dat_sync_r;

  // Register both lines every cycle; reset to the released (pulled-up) level.
  always_ff @(posedge clock_quarter) begin
    if (reset) begin
      clk_sync_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_sync_r <= clk_in;
      dat_sync_r <= dat_in;
    end
  end

  assign clk_sync = clk_sync_r;
  assign dat_sync = dat_sync_r;

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx
//   Device-to-host PS/2 transmitter (keyboard side, device owns PS2_CLK).
//   Sends one byte per accepted request as an 11-bit frame, LSB first:
//   start(0), data[7:0], odd parity, stop(1). Each bit is 4 cycles long.
//   Ports:
//     clock_quarter  in     system clock, 4 cycles per PS/2 bit
//     reset          in     synchronous, active-high
//     start          in     request to send, only looked at while ready
//     data[7:0]      in     byte to send, captured when start is accepted
//     ready          out    1 while idle
//     finish         out    one-cycle pulse when the frame completes or aborts
//     faild          out    1 when the last request aborted (valid after finish)
//     PS2_CLK        inout  open-drain clock: drives 0 or z
//     PS2_DAT        inout  open-drain data: drives 0 or z
module ps2_tx
  import ps2_tx_pkg::*;
#(
  parameter int BUS_IDLE_CYCLES = 4,
  parameter int BUS_TIMEOUT     = 20
) (
  input  logic       clock_quarter,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       finish,
  output logic       faild,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  localparam logic [7:0] IDLE_LAST   = 8'(BUS_IDLE_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_MAX = 8'(BUS_TIMEOUT);

  ps2_state_e state_r;
  ps2_state_e state_next_s;

  logic [PS2_FRAME_BITS-1:0] shift_r;
  logic [1:0]                bit_cnt_r;
  logic [3:0]                frame_cnt_r;
  logic [7:0]                idle_cnt_r;
  logic [7:0]                wait_cnt_r;
  logic                      faild_r;

  logic clk_sync_s;
  logic dat_sync_s;
  logic bus_idle_s;
  logic host_rts_s;
  logic inhibit_phase_s;
  logic finish_s;
  logic clk_low_s;
  logic dat_low_s;

  ps2_sync u_sync (
    .clock_quarter (clock_quarter),
    .reset         (reset),
    .clk_in        (PS2_CLK),
    .dat_in        (PS2_DAT),
    .clk_sync      (clk_sync_s),
    .dat_sync      (dat_sync_s)
  );

  assign bus_idle_s = clk_sync_s & dat_sync_s;
  // Host pulls data low while the clock is released: it wants to talk.
  assign host_rts_s = clk_sync_s & ~dat_sync_s;
  // Only in phases 0/1 does clk_sync reflect a clock we are not pulling low
  // ourselves, so a low reading there can only come from the host.
  assign inhibit_phase_s = (bit_cnt_r == PH_SETUP) || (bit_cnt_r == PH_LOW0);

  // State register.
  always_ff @(posedge clock_quarter) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and line/handshake outputs.
  always_comb begin
    state_next_s = state_r;
    finish_s     = 1'b0;
    clk_low_s    = 1'b0;
    dat_low_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_WAIT_BUS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_BUS: begin
        if (host_rts_s) begin
          state_next_s = ST_ABORT;
        end else if (bus_idle_s && (idle_cnt_r == IDLE_LAST)) begin
          state_next_s = ST_SEND;
        end else if (wait_cnt_r > TIMEOUT_MAX) begin
          state_next_s = ST_ABORT;
        end else begin
          state_next_s = ST_WAIT_BUS;
        end
      end
      ST_SEND: begin
        clk_low_s = (bit_cnt_r == PH_LOW0) || (bit_cnt_r == PH_LOW1);
        dat_low_s = ~shift_r[0];
        if (inhibit_phase_s && !clk_sync_s) begin
          state_next_s = ST_ABORT;
        end else if ((frame_cnt_r == STOP_BIT_IDX) && (bit_cnt_r == PH_HIGH)) begin
          finish_s     = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SEND;
        end
      end
      ST_ABORT: begin
        finish_s     = 1'b1;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Frame shifter, bit/frame/idle/wait counters and the abort flag.
  always_ff @(posedge clock_quarter) begin
    if (reset) begin
      shift_r     <= 11'h7FF;
      bit_cnt_r   <= 2'd0;
      frame_cnt_r <= 4'd0;
      idle_cnt_r  <= 8'd0;
      wait_cnt_r  <= 8'd0;
      faild_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r   <= 2'd0;
          frame_cnt_r <= 4'd0;
          idle_cnt_r  <= 8'd0;
          wait_cnt_r  <= 8'd0;
          if (start) begin
            shift_r <= {1'b1, odd_parity(data), data, 1'b0};
            faild_r <= 1'b0;
          end
        end
        ST_WAIT_BUS: begin
          bit_cnt_r   <= 2'd0;
          frame_cnt_r <= 4'd0;
          // Only an unbroken run of idle cycles counts.
          idle_cnt_r  <= bus_idle_s ? (idle_cnt_r + 8'd1) : 8'd0;
          wait_cnt_r  <= (wait_cnt_r == 8'hFF) ? 8'hFF : (wait_cnt_r + 8'd1);
          // Raise faild on the way into ABORT so it is already set while finish pulses.
          if (state_next_s == ST_ABORT) begin
            faild_r <= 1'b1;
          end
        end
        ST_SEND: begin
          idle_cnt_r <= 8'd0;
          wait_cnt_r <= 8'd0;
          bit_cnt_r  <= bit_cnt_r + 2'd1;
          // Advance at the end of the high phase so the data line moves at phase 0.
          if (bit_cnt_r == PH_HIGH) begin
            shift_r     <= {1'b1, shift_r[PS2_FRAME_BITS-1:1]};
            frame_cnt_r <= (frame_cnt_r == STOP_BIT_IDX) ? 4'd0 : (frame_cnt_r + 4'd1);
          end
          if (state_next_s == ST_ABORT) begin
            faild_r <= 1'b1;
          end
        end
        ST_ABORT: begin
          shift_r     <= 11'h7FF;
          bit_cnt_r   <= 2'd0;
          frame_cnt_r <= 4'd0;
          idle_cnt_r  <= 8'd0;
          wait_cnt_r  <= 8'd0;
          faild_r     <= 1'b1;
        end
        default: begin
          shift_r     <= 11'h7FF;
          bit_cnt_r   <= 2'd0;
          frame_cnt_r <= 4'd0;
          idle_cnt_r  <= 8'd0;
          wait_cnt_r  <= 8'd0;
          faild_r     <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = (state_r == ST_IDLE);
  assign finish = finish_s;
  assign faild  = faild_r;

  // Open-drain drivers: only ever pull low, otherwise release.
  assign PS2_CLK = clk_low_s ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low_s ? 1'b0 : 1'bz;

endmodule
